ps2_scan_ctrl: RTL



---
 rtl/ps2_pkg.sv | 15 +
 rtl/ps2_event_fifo.sv | 48 ++++
 rtl/ps2_scan_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Small synchronous FIFO of decoded key events; drops new events when full.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic       i_pop,
  input  ps2_event_t i_data,
  output logic       o_full,
  output logic       o_empty,
  output ps2_event_t o_head,
  output logic       o_drop
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  ps2_event_t  r_mem [FIFO_DEPTH];
  logic        w_pop;
  logic        w_wr;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_pop);
  assign o_drop  = i_push && o_full && !w_pop;
  assign o_head  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr)  r_wr <= r_wr + (AW+1)'(1);
      if (w_pop) r_rd <= r_rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ps2_scan_ctrl.sv
// PS/2 keyboard receiver: input sync, frame FSM with parity/stop/timeout
// checks, E0/F0 prefix folding and a buffered event output.
module ps2_scan_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_break,
  output logic       ev_ext,
  output logic       err_pulse,
  output logic       ovf_pulse
);

  localparam int            TW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

  logic          r_clk_s1, r_clk_s2, r_clk_d;
  logic          r_dat_s1, r_dat_s2;
  ps2_state_t    r_state, w_state_nxt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          r_ext, r_brk;
  logic [TW-1:0] r_tcnt;
  logic          w_fall, w_tout, w_stop_ev, w_good, w_err, w_push;
  logic          w_full, w_empty, w_drop, w_pop;
  ps2_event_t    w_event, w_head;

  // Lines idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_d  <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_d && !r_clk_s2;
  assign w_tout = (r_state != IDLE) && (r_tcnt == TLIM) && !w_fall;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_tout) begin
      w_state_nxt = IDLE;
    end else if (w_fall) begin
      case (r_state)
        IDLE:    if (!r_dat_s2) w_state_nxt = DATA;
        DATA:    if (r_idx == 3'd7) w_state_nxt = PARITY;
        PARITY:  w_state_nxt = STOP;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_stop_ev = w_fall && (r_state == STOP);
    w_good    = w_stop_ev && r_dat_s2 && (^{r_shift, r_par});
    w_err     = w_tout || (w_stop_ev && !w_good);
    w_push    = w_good && (r_shift != PS2_EXT) && (r_shift != PS2_BRK);
  end

  always_ff @(posedge clk) begin
    if (w_fall && r_state == DATA)   r_shift <= {r_dat_s2, r_shift[7:1]};
    if (w_fall && r_state == PARITY) r_par   <= r_dat_s2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx  <= '0;
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_tcnt <= '0;
    end else begin
      if (w_fall && r_state == IDLE)      r_idx <= '0;
      else if (w_fall && r_state == DATA) r_idx <= r_idx + 3'd1;
      if (w_err) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (w_good) begin
        if (r_shift == PS2_EXT)      r_ext <= 1'b1;
        else if (r_shift == PS2_BRK) r_brk <= 1'b1;
        else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
      if (w_fall || r_state == IDLE) r_tcnt <= '0;
      else                           r_tcnt <= r_tcnt + TW'(1);
    end
  end

  assign w_event = {r_shift, r_brk, r_ext};
  assign w_pop   = ev_valid && ev_ready;

  ps2_event_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_event),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head),
    .o_drop  (w_drop)
  );

  // Storage is not reset; mask the head so outputs read zero when empty.
  assign ev_valid  = !w_empty;
  assign ev_code   = w_empty ? 8'h00 : w_head.code;
  assign ev_break  = !w_empty && w_head.brk;
  assign ev_ext    = !w_empty && w_head.ext;
  assign err_pulse = w_err && !reset;
  assign ovf_pulse = w_drop && w_full && !reset;

endmodule
